// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback per instruction and drives
// every datapath enable and mux select. Memory states hold on mem_ready.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       ir_write,
    output logic [1:0] pc_source,
    output logic [1:0] aluop,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    // State encodings (also visible on the debug port)
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BEQ    = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;

    // Supported opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam int          NUM_OPS  = 6;
    localparam logic [35:0] OP_TABLE = {OP_ADDI, OP_J, OP_BEQ, OP_SW, OP_LW, OP_RTYPE};

    logic [3:0]         r_state;
    logic [3:0]         w_state_next;
    logic [NUM_OPS-1:0] w_op_hit;
    logic               w_op_legal;

    // One comparator per supported opcode; any hit makes the opcode legal
    genvar gi;
    generate
        for (gi = 0; gi < NUM_OPS; gi++) begin : g_op_hit
            assign w_op_hit[gi] = (opcode == OP_TABLE[gi*6 +: 6]);
        end
    endgenerate

    assign w_op_legal = |w_op_hit;
    assign state      = r_state;

    // State register; reset lands in FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; unused codes 12-15 fall back to FETCH
    always_comb begin
        w_state_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_state_next = S_MEMADR;
                    OP_RTYPE:     w_state_next = S_EXEC;
                    OP_BEQ:       w_state_next = S_BEQ;
                    OP_J:         w_state_next = S_JUMP;
                    OP_ADDI:      w_state_next = S_ADDIEX;
                    default:      w_state_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_state_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_state_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_state_next = S_RWB;
            S_ADDIEX: w_state_next = S_ADDIWB;
            S_MEMWB, S_RWB, S_BEQ, S_JUMP, S_ADDIWB: w_state_next = S_FETCH;
            default:  w_state_next = S_FETCH;
        endcase
    end

    // Output decode; everything is quiet while reset is held so an abandoned
    // instruction cannot write anything
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        pc_source     = 2'b00;
        aluop         = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    // PC and IR load only in the cycle memory delivers, so a
                    // stalled fetch updates them exactly once
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    // Branch target computed speculatively into ALUOut
                    alu_src_b  = 2'b11;
                    illegal_op = ~w_op_legal;
                    instr_done = ~w_op_legal;
                end
                S_MEMADR, S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEMWR: begin
                    mem_write  = 1'b1;
                    iord       = 1'b1;
                    instr_done = mem_ready;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    aluop     = 2'b10;
                end
                S_RWB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                end
                S_ADDIWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_BEQ: begin
                    alu_src_a     = 1'b1;
                    aluop         = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    instr_done    = 1'b1;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    instr_done = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class
// cycle by cycle and checks state plus every control output.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write;
    logic       mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst;
    logic       instr_done, illegal_op;
    logic [1:0] pc_source, aluop, alu_src_b;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;
    int step  = 0;

    multicycle_control dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .ir_write      (ir_write),
        .pc_source     (pc_source),
        .aluop         (aluop),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field order: pcw,pcwc,iord,mrd,mwr,m2r,irw,pcsrc[2],aluop[2],srca,srcb[2],rw,rdst,done,ill
    logic [17:0] ctrl;
    assign ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, mem_to_reg,
                   ir_write, pc_source, aluop, alu_src_a, alu_src_b, reg_write,
                   reg_dst, instr_done, illegal_op};

    localparam logic [17:0] C_ZERO   = 18'd0;
    //                                 pcw   pcwc  iord  mrd   mwr   m2r   irw   pcsrc  aluop  srca  srcb   rw    rdst  done  ill
    localparam logic [17:0] C_F_RDY  = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] C_F_WAIT = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] C_DEC    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] C_DECILL = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [17:0] C_MADR   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] C_MRD    = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] C_MWR_W  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] C_MWR_R  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [17:0] C_MWB    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [17:0] C_EXEC   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] C_RWB    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam logic [17:0] C_AWB    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [17:0] C_BEQ    = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [17:0] C_JMP    = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ILL  = 6'b111111;

    // One clock cycle: drive inputs, sample mid-cycle on the falling edge,
    // then move just past the next rising edge
    task automatic cyc(input string tag, input logic rst, input logic [5:0] opc,
                       input logic rdy, input logic [3:0] exp_state,
                       input logic [17:0] exp_ctrl);
        reset     = rst;
        opcode    = opc;
        mem_ready = rdy;
        step++;
        @(negedge clk);
        total++;
        assert (state === exp_state) else begin
            bad++;
            $error("FAIL step%0d %s.state observed=%0d expected=%0d", step, tag, state, exp_state);
        end
        total++;
        assert (ctrl === exp_ctrl) else begin
            bad++;
            $error("FAIL step%0d %s.ctrl observed=%b expected=%b", step, tag, ctrl, exp_ctrl);
        end
        $display("step%0d %s state=%0d ctrl=%b", step, tag, state, ctrl);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = OP_R;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset held: FETCH reached, outputs forced low even with mem_ready high
        cyc("rst0", 1'b1, OP_LW, 1'b1, 4'd0, C_ZERO);
        cyc("rst1", 1'b1, OP_LW, 1'b1, 4'd0, C_ZERO);

        // lw, memory always ready: 0,1,2,3,4
        cyc("lw_fetch",  1'b0, OP_LW, 1'b1, 4'd0, C_F_RDY);
        cyc("lw_dec",    1'b0, OP_LW, 1'b1, 4'd1, C_DEC);
        cyc("lw_madr",   1'b0, OP_LW, 1'b1, 4'd2, C_MADR);
        cyc("lw_mrd",    1'b0, OP_LW, 1'b1, 4'd3, C_MRD);
        cyc("lw_mwb",    1'b0, OP_LW, 1'b1, 4'd4, C_MWB);

        // R-type, mem_ready low in non-memory states must not matter
        cyc("r_fetch",   1'b0, OP_R, 1'b1, 4'd0, C_F_RDY);
        cyc("r_dec",     1'b0, OP_R, 1'b0, 4'd1, C_DEC);
        cyc("r_exec",    1'b0, OP_R, 1'b0, 4'd6, C_EXEC);
        cyc("r_rwb",     1'b0, OP_R, 1'b0, 4'd7, C_RWB);

        // beq
        cyc("beq_fetch", 1'b0, OP_BEQ, 1'b1, 4'd0, C_F_RDY);
        cyc("beq_dec",   1'b0, OP_BEQ, 1'b1, 4'd1, C_DEC);
        cyc("beq_beq",   1'b0, OP_BEQ, 1'b0, 4'd8, C_BEQ);

        // sw with three wait cycles in MEMWR, then a two-cycle fetch stall
        cyc("sw_fetch",  1'b0, OP_SW, 1'b1, 4'd0, C_F_RDY);
        cyc("sw_dec",    1'b0, OP_SW, 1'b1, 4'd1, C_DEC);
        cyc("sw_madr",   1'b0, OP_SW, 1'b1, 4'd2, C_MADR);
        cyc("sw_wait0",  1'b0, OP_SW, 1'b0, 4'd5, C_MWR_W);
        cyc("sw_wait1",  1'b0, OP_SW, 1'b0, 4'd5, C_MWR_W);
        cyc("sw_wait2",  1'b0, OP_SW, 1'b0, 4'd5, C_MWR_W);
        cyc("sw_done",   1'b0, OP_SW, 1'b1, 4'd5, C_MWR_R);
        cyc("f_stall0",  1'b0, OP_J, 1'b0, 4'd0, C_F_WAIT);
        cyc("f_stall1",  1'b0, OP_J, 1'b0, 4'd0, C_F_WAIT);

        // j (fetch completes after the stall)
        cyc("j_fetch",   1'b0, OP_J, 1'b1, 4'd0, C_F_RDY);
        cyc("j_dec",     1'b0, OP_J, 1'b1, 4'd1, C_DEC);
        cyc("j_jump",    1'b0, OP_J, 1'b1, 4'd9, C_JMP);

        // illegal opcode retires in DECODE, back to FETCH
        cyc("ill_fetch", 1'b0, OP_ILL, 1'b1, 4'd0, C_F_RDY);
        cyc("ill_dec",   1'b0, OP_ILL, 1'b1, 4'd1, C_DECILL);
        cyc("ill_back",  1'b0, OP_ILL, 1'b0, 4'd0, C_F_WAIT);

        // addi
        cyc("ad_fetch",  1'b0, OP_ADDI, 1'b1, 4'd0, C_F_RDY);
        cyc("ad_dec",    1'b0, OP_ADDI, 1'b1, 4'd1, C_DEC);
        cyc("ad_ex",     1'b0, OP_ADDI, 1'b1, 4'd10, C_MADR);
        cyc("ad_wb",     1'b0, OP_ADDI, 1'b1, 4'd11, C_AWB);

        // lw with one MEMRD wait, then reset lands mid-instruction
        cyc("lr_fetch",  1'b0, OP_LW, 1'b1, 4'd0, C_F_RDY);
        cyc("lr_dec",    1'b0, OP_LW, 1'b1, 4'd1, C_DEC);
        cyc("lr_madr",   1'b0, OP_LW, 1'b1, 4'd2, C_MADR);
        cyc("lr_mrdw",   1'b0, OP_LW, 1'b0, 4'd3, C_MRD);
        cyc("lr_rst",    1'b1, OP_LW, 1'b1, 4'd3, C_ZERO);
        cyc("lr_rst2",   1'b1, OP_LW, 1'b1, 4'd0, C_ZERO);
        cyc("lr_post",   1'b0, OP_LW, 1'b1, 4'd0, C_F_RDY);
        cyc("lr_dec2",   1'b0, OP_LW, 1'b1, 4'd1, C_DEC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
